// File: rtl/hex_debug_panel.sv
// rtl/hex_debug_panel.sv - paged seven-segment debug display driver with freeze, blank and blink
module hex_debug_panel #(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_PAGES  = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCROLL_DIV = 100000000,
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
  input  logic                            step,
  input  logic                            auto_scroll,
  input  logic                            freeze,
  input  logic [NUM_DIGITS-1:0]           blank_mask,
  input  logic [NUM_DIGITS-1:0]           blink_mask,
  output logic [NUM_DIGITS*7-1:0]         hex_out,
  output logic [PAGE_W-1:0]               page,
  output logic                            frozen
);

  localparam int WORD_W   = NUM_DIGITS * 4;
  localparam int DATA_W   = NUM_PAGES * WORD_W;
  localparam int BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [PAGE_W-1:0]   PAGE_LAST   = PAGE_W'(NUM_PAGES - 1);

  logic                  step_q;
  logic                  freeze_q;
  logic                  step_edge;
  logic                  freeze_edge;
  logic                  scroll_tick;
  logic [SCROLL_W-1:0]   scroll_cnt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [DATA_W-1:0]     snapshot;
  logic [DATA_W-1:0]     source;
  logic [WORD_W-1:0]     cur_word;
  logic [NUM_DIGITS*7-1:0] next_hex;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Edge registers reset high so inputs already asserted at release do not count as edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= 1'b1;
      freeze_q <= 1'b1;
    end else begin
      step_q   <= step;
      freeze_q <= freeze;
    end
  end

  assign step_edge   = step & ~step_q;
  assign freeze_edge = freeze & ~freeze_q;
  assign scroll_tick = auto_scroll && (scroll_cnt == SCROLL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_cnt <= '0;
    end else if (!auto_scroll || step_edge || scroll_tick) begin
      scroll_cnt <= '0;
    end else begin
      scroll_cnt <= scroll_cnt + SCROLL_W'(1);
    end
  end

  // A coincident step edge and scroll tick still advance by a single page.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page <= '0;
    end else if (step_edge || scroll_tick) begin
      page <= (page == PAGE_LAST) ? '0 : page + PAGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
      frozen   <= 1'b0;
    end else if (freeze_edge) begin
      snapshot <= page_data;
      frozen   <= 1'b1;
    end else if (!freeze) begin
      frozen   <= 1'b0;
    end
  end

  always_comb begin
    source   = frozen ? snapshot : page_data;
    cur_word = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (int'(page) == p) begin
        cur_word = source[p*WORD_W +: WORD_W];
      end
    end
  end

  // Blank wins over blink; blink only darkens during the off phase.
  always_comb begin
    next_hex = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (blank_mask[d]) begin
        next_hex[d*7 +: 7] = 7'h7f;
      end else if (blink_mask[d] && blink_phase) begin
        next_hex[d*7 +: 7] = 7'h7f;
      end else begin
        next_hex[d*7 +: 7] = seg_encode(cur_word[d*4 +: 4]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_out <= '1;
    end else begin
      hex_out <= next_hex;
    end
  end

endmodule

// File: tb/tb_hex_debug_panel.sv
// tb/tb_hex_debug_panel.sv - self-checking bench for hex_debug_panel
module tb_hex_debug_panel;

  localparam int ND = 8;
  localparam int NP = 4;
  localparam int BD = 4;
  localparam int SD = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            step;
  logic            auto_scroll;
  logic            freeze;
  logic [NP*ND*4-1:0] page_data;
  logic [ND-1:0]   blank_mask;
  logic [ND-1:0]   blink_mask;
  logic [ND*7-1:0] hex_out;
  logic [1:0]      page;
  logic            frozen;

  logic [ND*4-1:0] page_data1;
  logic [ND*7-1:0] hex_out1;
  logic            page1;
  logic            frozen1;

  assign page_data1 = page_data[ND*4-1:0];

  hex_debug_panel #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .BLINK_DIV(BD), .SCROLL_DIV(SD)) dut (
    .clk(clk), .reset(reset), .page_data(page_data), .step(step),
    .auto_scroll(auto_scroll), .freeze(freeze), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .hex_out(hex_out), .page(page), .frozen(frozen)
  );

  hex_debug_panel #(.NUM_DIGITS(ND), .NUM_PAGES(1), .BLINK_DIV(BD), .SCROLL_DIV(SD)) dut1 (
    .clk(clk), .reset(reset), .page_data(page_data1), .step(step),
    .auto_scroll(auto_scroll), .freeze(freeze), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .hex_out(hex_out1), .page(page1), .frozen(frozen1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: whole-panel state, advanced once per clock from the behavioural rules.
  int              m_page, n_page;
  int              m_sc, n_sc;
  int              m_n;
  bit              m_frozen, n_frozen;
  bit              m_step_q, n_step_q;
  bit              m_freeze_q, n_freeze_q;
  logic [NP*ND*4-1:0] m_snap, n_snap;
  logic [ND*7-1:0] m_hex, n_hex;

  task automatic model_reset();
    m_page = 0; m_sc = 0; m_n = 0; m_frozen = 0;
    m_step_q = 1; m_freeze_q = 1; m_snap = '0; m_hex = '1;
  endtask

  task automatic predict();
    bit sr, tick, fr;
    int phase;
    logic [NP*ND*4-1:0] src;
    logic [3:0] nib;
    sr     = step && !m_step_q;
    tick   = auto_scroll && (m_sc == SD - 1);
    n_page = (sr || tick) ? (m_page + 1) % NP : m_page;
    n_sc   = (!auto_scroll || sr || tick) ? 0 : m_sc + 1;
    phase  = (m_n / BD) % 2;
    src    = m_frozen ? m_snap : page_data;
    for (int d = 0; d < ND; d++) begin
      nib = src[(m_page*ND + d)*4 +: 4];
      if (blank_mask[d]) n_hex[d*7 +: 7] = 7'h7f;
      else if (blink_mask[d] && phase == 1) n_hex[d*7 +: 7] = 7'h7f;
      else n_hex[d*7 +: 7] = seg_lut[nib];
    end
    fr         = freeze && !m_freeze_q;
    n_snap     = fr ? page_data : m_snap;
    n_frozen   = fr ? 1'b1 : (freeze ? m_frozen : 1'b0);
    n_step_q   = step;
    n_freeze_q = freeze;
  endtask

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
    m_page = n_page; m_sc = n_sc; m_n++; m_frozen = n_frozen;
    m_step_q = n_step_q; m_freeze_q = n_freeze_q; m_snap = n_snap; m_hex = n_hex;
    check("model_page", 64'(page), 64'(m_page));
    check("model_frozen", 64'(frozen), 64'(m_frozen));
    check("model_hex", 64'(hex_out), 64'(m_hex));
    check("np1_page", 64'(page1), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_hex", 64'(hex_out), 64'({ND*7{1'b1}}));
    check("rst_page", 64'(page), 64'(0));
    check("rst_frozen", 64'(frozen), 64'(0));
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [31:0]     data;
    logic [7:0]      blank;
    logic [ND*7-1:0] exp;
  } vec_t;

  vec_t vecs [5];
  int dark0, dark7;

  initial begin
    vecs[0] = '{32'h12345678, 8'h00, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[1] = '{32'h9ABCDEF0, 8'h00, {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}};
    vecs[2] = '{32'h12345678, 8'hFF, {ND*7{1'b1}}};
    vecs[3] = '{32'h00000000, 8'h0F, {7'h40, 7'h40, 7'h40, 7'h40, 7'h7f, 7'h7f, 7'h7f, 7'h7f}};
    vecs[4] = '{32'h88888888, 8'hA5, {7'h7f, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h7f, 7'h00, 7'h7f}};

    reset = 1'b1; step = 1'b1; freeze = 1'b1; auto_scroll = 1'b0;
    blank_mask = '0; blink_mask = '0;
    page_data = {32'h0BADF00D, 32'hCAFE0000, 32'h9ABCDEF0, 32'h12345678};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("init_hex", 64'(hex_out), 64'({ND*7{1'b1}}));
    check("init_page", 64'(page), 64'(0));
    check("init_frozen", 64'(frozen), 64'(0));
    cycle();
    check("held_freeze_no_edge", 64'(frozen), 64'(0));
    check("digit0_of_12345678", 64'(hex_out[6:0]), 64'(7'h00));
    check("digit7_of_12345678", 64'(hex_out[55:49]), 64'(7'h79));
    check("digit4_of_12345678", 64'(hex_out[34:28]), 64'(7'h19));
    freeze = 1'b0; step = 1'b0;
    cycle();

    for (int i = 0; i < 5; i++) begin
      page_data[31:0] = vecs[i].data;
      blank_mask = vecs[i].blank;
      cycle();
      check($sformatf("vec%0d_hex", i), 64'(hex_out), 64'(vecs[i].exp));
    end
    blank_mask = '0;

    for (int i = 0; i < 5; i++) begin
      step = 1'b1; cycle();
      check($sformatf("step_pulse%0d_page", i), 64'(page), 64'((i + 1) % 4));
      step = 1'b0; cycle(); cycle();
    end
    step = 1'b1;
    repeat (10) cycle();
    check("step_held_page", 64'(page), 64'(2));
    step = 1'b0; cycle();

    auto_scroll = 1'b1;
    repeat (7) cycle();
    check("scroll_before_tick", 64'(page), 64'(2));
    cycle();
    check("scroll_tick1", 64'(page), 64'(3));
    repeat (7) cycle();
    step = 1'b1; cycle();
    check("scroll_tick_and_step", 64'(page), 64'(0));
    step = 1'b0;
    repeat (7) cycle();
    check("scroll_after_step_wait", 64'(page), 64'(0));
    cycle();
    check("scroll_tick_after_step", 64'(page), 64'(1));
    auto_scroll = 1'b0;
    repeat (20) cycle();
    check("scroll_disabled", 64'(page), 64'(1));

    blink_mask = 8'h01; blank_mask = 8'h80;
    dark0 = 0; dark7 = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (hex_out[6:0] == 7'h7f) dark0++;
      if (hex_out[55:49] == 7'h7f) dark7++;
    end
    check("blink_dark_count", 64'(dark0), 64'(8));
    check("blank_dark_count", 64'(dark7), 64'(16));
    blink_mask = '0; blank_mask = '0;

    page_data = {32'h0BADF00D, 32'hCAFE0000, 32'h9ABCDEF0, 32'h12345678};
    step = 1'b1; cycle(); step = 1'b0; cycle();
    check("freeze_page2", 64'(page), 64'(2));
    freeze = 1'b1; cycle();
    check("freeze_frozen", 64'(frozen), 64'(1));
    page_data = '0; cycle();
    check("freeze_cafe", 64'(hex_out), 64'({7'h46, 7'h08, 7'h0E, 7'h06, 7'h40, 7'h40, 7'h40, 7'h40}));
    step = 1'b1; cycle(); step = 1'b0; cycle();
    check("freeze_page3_snap", 64'(hex_out), 64'({7'h40, 7'h03, 7'h08, 7'h21, 7'h0E, 7'h40, 7'h40, 7'h21}));
    freeze = 1'b0; cycle();
    check("unfreeze_frozen", 64'(frozen), 64'(0));
    cycle();
    check("unfreeze_live", 64'(hex_out), 64'({ND{7'h40}}));
    freeze = 1'b1; cycle(); cycle();
    do_reset();
    freeze = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) auto_scroll = ~auto_scroll;
      if ($urandom_range(0, 19) == 0) freeze = ~freeze;
      if ($urandom_range(0, 9) == 0) begin
        blank_mask = 8'($urandom) & 8'($urandom);
        blink_mask = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0) page_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_debug_panel.md
Name: hex_debug_panel

Overview:
- Parametrised, paged seven-segment debug display driver for the DE2 HEX0..HEX7 bank.
- Replaces hard-wired per-digit hexdigit instances in the board top level. Several debug words (VGA x/y, keycode, FSM state, obstacle memory, ...) are presented as pages.
- Pages are selected by a key step or by timed auto-scroll.
- Supports freeze (snapshot), per-digit blanking and per-digit blinking. All segment outputs are registered.

Parameters:
- NUM_DIGITS, 8: digits driven; each digit takes one 4-bit nibble.
- NUM_PAGES, 4: number of selectable pages, at least 1.
- BLINK_DIV, 25000000: clk cycles per blink half-period (0.5 s at 50 MHz).
- SCROLL_DIV, 100000000: clk cycles between auto-scroll page advances.

Ports:
- clk, input, 1: system clock (CLOCK_50 domain).
- reset, input, 1: asynchronous, active-high reset.
- page_data, input, NUM_PAGES*NUM_DIGITS*4: flattened page words. Page p, digit d is at bits [(p*NUM_DIGITS+d)*4 +: 4].
- step, input, 1: page-advance request. Level input; acts on its rising edge only.
- auto_scroll, input, 1: enables timed page advance.
- freeze, input, 1: while high, the display shows the snapshot taken on the rising edge of freeze.
- blank_mask, input, NUM_DIGITS: a 1 in bit d forces digit d dark.
- blink_mask, input, NUM_DIGITS: a 1 in bit d makes digit d dark during the off phase of the blink.
- hex_out, output, NUM_DIGITS*7: active-low segments. Digit d is at [d*7 +: 7]; bit 0 is segment a and bit 6 is segment g.
- page, output, max(1,clog2(NUM_PAGES)): currently selected page.
- frozen, output, 1: high while the snapshot is being displayed.

Behaviour:
- Reset values (asynchronous):
  - page=0, frozen=0.
  - Every hex_out digit = 7'h7f (dark).
  - Blink counter, blink phase, scroll counter and snapshot register all = 0.
  - Edge registers for step and freeze reset to 1, so an input already high at reset release produces no edge.
- Step edge: step_q registers step. The edge condition is step & ~step_q.
- Page advance: page+1 on a step edge or on a scroll tick. Wraps from NUM_PAGES-1 to 0. When NUM_PAGES=1, page stays 0.
- A step edge and a scroll tick in the same cycle advance the page by exactly 1, not 2.
- Scroll counter:
  - Counts 0..SCROLL_DIV-1 while auto_scroll=1. The scroll tick occurs on the cycle the counter equals SCROLL_DIV-1; the counter then returns to 0.
  - auto_scroll=0 holds the counter at 0.
  - A step edge clears the counter, so the next auto advance comes a full SCROLL_DIV later.
- Blink counter:
  - Free-running 0..BLINK_DIV-1. The blink phase toggles when the counter wraps.
  - Phase 0 = on, phase 1 = off.
- Freeze:
  - On the rising edge of freeze, all of page_data is copied into the snapshot register and frozen goes to 1 on the same clock edge.
  - frozen follows freeze falling with a 1-cycle lag (frozen <= 0 on the first cycle freeze is sampled low).
  - Paging, blink and scroll all stay active while frozen; only the data source changes.
- Source nibble for digit d: snapshot when frozen=1, else page_data, in both cases for the current page.
- Blanking precedence per digit:
  1. blank_mask[d] gives 7'h7f.
  2. Otherwise, blink_mask[d] with phase 1 gives 7'h7f.
  3. Otherwise, the hex encoding of the nibble.
- Encoding (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Latency:
  - hex_out is registered: a change in page_data, blank_mask or blink_mask appears on hex_out 1 clk later.
  - A page change reaches hex_out 1 clk after page updates.
  - A freeze edge freezes the value that was on page_data in the edge cycle.
- Reset mid-operation (e.g. mid-scroll or while frozen): immediately returns to the reset values, and the snapshot is discarded.
- All counter widths are sized by clog2 of their divider. No combinational path from inputs to hex_out.

Test Plan:
- Reset held, then released with step=1, freeze=1: all digits 7'h7f, page=0 and frozen=0 on the first cycle. After 1 clk (freeze still high, no edge), frozen stays 0.
- Page 0 data = 0x12345678 (default parameters), masks 0: 1 clk later, digit0 = 7'h00 (8) and digit7 = 7'h79 (1). Digit4 = 7'h19 (4).
- NUM_PAGES=4: five step pulses, 1 cycle high and 2 low each → page reads 1,2,3,0,1. step held high for 10 cycles → exactly one advance.
- SCROLL_DIV=8, auto_scroll=1: page advances every 8 clk.
  - A step edge in the tick cycle → +1 only, and the next tick is 8 clk later.
  - auto_scroll=0 → page stays put.
- BLINK_DIV=4, blink_mask=0x01, blank_mask=0x80: digit0 alternates nibble / 7'h7f every 4 clk. Digit7 stays 7'h7f.
- Freeze with page 2 = 0xCAFE0000, then change page_data to 0: display still shows CAFE0000. Step to page 3 shows the snapshot of page 3. Dropping freeze → frozen=0 next cycle and live data returns. Asserting reset while frozen → all dark, page 0.
